// File: rtl/axis_upsize_64to256.sv
// AXI-Stream width upsizer: packs four 64-bit beats into one 256-bit word,
// flushing early on tlast, with frame and bad-frame counters.
module axis_upsize_64to256 #(
   parameter int S_DATA_W = 64,
   parameter int M_DATA_W = 256,
   parameter int CNT_W    = 32
) (
   input  logic                  SysClk,
   input  logic                  Rst,
   input  logic [S_DATA_W-1:0]   s_axis_tdata,
   input  logic [S_DATA_W/8-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [M_DATA_W-1:0]   m_axis_tdata,
   output logic [M_DATA_W/8-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic [CNT_W-1:0]      stat_frames,
   output logic [CNT_W-1:0]      stat_bad_frames
);

   localparam int S_KEEP_W = S_DATA_W / 8;
   localparam int M_KEEP_W = M_DATA_W / 8;

   logic [M_DATA_W-1:0] data_q, data_d;
   logic [M_KEEP_W-1:0] keep_q, keep_d;
   logic [1:0]          lane_q, lane_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                user_q, user_d;
   logic                sticky_q, sticky_d;
   logic [CNT_W-1:0]    frames_q, frames_d;
   logic [CNT_W-1:0]    bad_q, bad_d;
   logic                drain, accept;

   assign s_axis_tready = !Rst && (!valid_q || m_axis_tready);
   assign drain         = valid_q && m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      data_d   = data_q;
      keep_d   = keep_q;
      lane_d   = lane_q;
      valid_d  = valid_q;
      last_d   = last_q;
      user_d   = user_q;
      sticky_d = sticky_q;
      frames_d = frames_q;
      bad_d    = bad_q;

      // A draining word is wiped so the next beat lands on a clean register.
      if (drain) begin
         valid_d = 1'b0;
         data_d  = '0;
         keep_d  = '0;
         last_d  = 1'b0;
         user_d  = 1'b0;
         if (last_q) begin
            frames_d = frames_q + CNT_W'(1);
            if (user_q) bad_d = bad_q + CNT_W'(1);
         end
      end

      if (accept) begin
         data_d[int'(lane_q)*S_DATA_W +: S_DATA_W] = s_axis_tdata;
         keep_d[int'(lane_q)*S_KEEP_W +: S_KEEP_W] = s_axis_tkeep;
         if (lane_q == 2'd3 || s_axis_tlast) begin
            valid_d  = 1'b1;
            lane_d   = '0;
            last_d   = s_axis_tlast;
            user_d   = s_axis_tlast && (sticky_q || s_axis_tuser);
            sticky_d = !s_axis_tlast && (sticky_q || s_axis_tuser);
         end else begin
            lane_d   = lane_q + 2'd1;
            sticky_d = sticky_q || s_axis_tuser;
         end
      end
   end

   always_ff @(posedge SysClk or posedge Rst) begin
      if (Rst) begin
         data_q   <= '0;
         keep_q   <= '0;
         lane_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         user_q   <= 1'b0;
         sticky_q <= 1'b0;
         frames_q <= '0;
         bad_q    <= '0;
      end else begin
         data_q   <= data_d;
         keep_q   <= keep_d;
         lane_q   <= lane_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         user_q   <= user_d;
         sticky_q <= sticky_d;
         frames_q <= frames_d;
         bad_q    <= bad_d;
      end
   end

   assign m_axis_tdata    = data_q;
   assign m_axis_tkeep    = keep_q;
   assign m_axis_tvalid   = valid_q;
   assign m_axis_tlast    = last_q;
   assign m_axis_tuser    = user_q;
   assign stat_frames     = frames_q;
   assign stat_bad_frames = bad_q;

endmodule

// File: tb/tb_axis_upsize_64to256.sv
// Randomized scoreboard bench for axis_upsize_64to256: expected words are
// built per frame by grouping beats four at a time.
module tb_axis_upsize_64to256;

   localparam int CNT_W = 32;

   logic             SysClk = 1'b0;
   logic             Rst = 1'b1;
   logic [63:0]      s_axis_tdata = '0;
   logic [7:0]       s_axis_tkeep = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tlast = 1'b0;
   logic             s_axis_tuser = 1'b0;
   logic             s_axis_tready;
   logic [255:0]     m_axis_tdata;
   logic [31:0]      m_axis_tkeep;
   logic             m_axis_tvalid;
   logic             m_axis_tlast;
   logic             m_axis_tuser;
   logic             m_axis_tready = 1'b1;
   logic [CNT_W-1:0] stat_frames;
   logic [CNT_W-1:0] stat_bad_frames;

   axis_upsize_64to256 #(.S_DATA_W(64), .M_DATA_W(256), .CNT_W(CNT_W)) dut (
      .SysClk(SysClk), .Rst(Rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
      .stat_frames(stat_frames), .stat_bad_frames(stat_bad_frames)
   );

   always #5 SysClk = ~SysClk;

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  k;
      logic         l;
      logic         u;
   } word_t;

   word_t            exp_q[$];
   logic [63:0]      fd[$];
   logic [7:0]       fk[$];
   logic             fu[$];
   logic [CNT_W-1:0] mdl_frames = '0;
   logic [CNT_W-1:0] mdl_bad = '0;
   int               n_checks = 0;
   int               n_err = 0;
   int               rdy_mode = 0;
   bit               stall_prev = 1'b0;
   word_t            held;

   task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected output words of the frame currently held in fd/fk/fu.
   task automatic build_expected();
      int    n  = fd.size();
      int    nw = (n + 3) / 4;
      logic  bad = 1'b0;
      word_t w;
      foreach (fu[i]) bad |= fu[i];
      for (int wi = 0; wi < nw; wi++) begin
         w = '0;
         for (int l = 0; l < 4; l++) begin
            if (4*wi + l < n) begin
               w.d[64*l +: 64] = fd[4*wi + l];
               w.k[8*l +: 8]   = fk[4*wi + l];
            end
         end
         w.l = (wi == nw - 1);
         w.u = w.l && bad;
         exp_q.push_back(w);
      end
   endtask

   task automatic make_frame(input int n, input int user_pct);
      fd.delete(); fk.delete(); fu.delete();
      for (int i = 0; i < n; i++) begin
         fd.push_back({$urandom, $urandom});
         fk.push_back(8'($urandom));
         fu.push_back($urandom_range(0, 99) < user_pct);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the last accepted beat.
   task automatic send_frame(input int n_send, input bit push, input int gap_max);
      bit ok;
      if (push) build_expected();
      for (int i = 0; i < n_send; i++) begin
         if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, gap_max)) begin @(posedge SysClk); #1; end
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = fd[i];
         s_axis_tkeep  = fk[i];
         s_axis_tuser  = fu[i];
         s_axis_tlast  = (i == fd.size() - 1);
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge SysClk);
            ok = s_axis_tready;
            @(posedge SysClk); #1;
         end
         if (!ok) check("beat_accept_timeout", 0, 1);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin @(posedge SysClk); #1; end
      check("drain_timeout", exp_q.size(), 0);
      @(posedge SysClk); #1;
   endtask

   initial begin
      forever begin
         @(posedge SysClk); #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge SysClk) begin
      word_t w;
      if (!Rst) begin
         check("s_tready", s_axis_tready, !m_axis_tvalid || m_axis_tready);
         check("stat_frames", stat_frames, mdl_frames);
         check("stat_bad", stat_bad_frames, mdl_bad);
         if (stall_prev) begin
            check("stall_valid", m_axis_tvalid, 1);
            check("stall_hold", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, held);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", m_axis_tdata, 0);
            end else begin
               w = exp_q.pop_front();
               check("tdata", m_axis_tdata, w.d);
               check("tkeep", m_axis_tkeep, w.k);
               check("tlast", m_axis_tlast, w.l);
               check("tuser", m_axis_tuser, w.u);
               if (w.l) begin
                  mdl_frames = mdl_frames + 1'b1;
                  if (w.u) mdl_bad = mdl_bad + 1'b1;
               end
            end
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      @(negedge SysClk);
      check({tag, "_tvalid"}, m_axis_tvalid, 0);
      check({tag, "_s_tready"}, s_axis_tready, 0);
      check({tag, "_out"}, {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
      check({tag, "_stats"}, {stat_frames, stat_bad_frames}, 0);
   endtask

   initial begin
      repeat (2) @(posedge SysClk);
      check_reset_outputs("rst0");
      @(posedge SysClk); #1;
      Rst = 1'b0;
      @(posedge SysClk); #1;

      // Full 4-beat frame, 1-cycle latency.
      rdy_mode = 0;
      fd = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
      fk = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      fu = '{1'b0, 1'b0, 1'b0, 1'b0};
      send_frame(4, 1'b1, 0);
      check("t1_latency_valid", m_axis_tvalid, 1);
      check("t1_keep", m_axis_tkeep, 32'hFFFFFFFF);
      check("t1_last", m_axis_tlast, 1);
      @(posedge SysClk); #1;
      check("t1_valid_drop", m_axis_tvalid, 0);
      check("t1_frames", stat_frames, 1);

      // Single-beat partial-keep frame.
      fd = '{64'hA5A5_5A5A_DEAD_BEEF};
      fk = '{8'h0F};
      fu = '{1'b0};
      send_frame(1, 1'b1, 0);
      check("t2_data", m_axis_tdata, {192'h0, 64'hA5A5_5A5A_DEAD_BEEF});
      check("t2_keep", m_axis_tkeep, 32'h0000000F);
      wait_idle();

      // 6-beat frame, bad flag on beat 1 only.
      make_frame(6, 0);
      foreach (fk[i]) fk[i] = 8'hFF;
      fk[5] = 8'h3F;
      fu[1] = 1'b1;
      send_frame(6, 1'b1, 0);
      check("t3_w1_keep", m_axis_tkeep, 32'h00003FFF);
      check("t3_w1_user", m_axis_tuser, 1);
      wait_idle();
      check("t3_frames", stat_frames, 3);
      check("t3_bad", stat_bad_frames, 1);

      // Back-to-back frames with ready toggling every cycle.
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) begin
         make_frame($urandom_range(1, 9), 20);
         send_frame(fd.size(), 1'b1, 0);
      end
      wait_idle();

      // Random frames, random gaps, random ready; includes keep=0 tlast beats.
      rdy_mode = 2;
      for (int f = 0; f < 30; f++) begin
         make_frame($urandom_range(1, 12), 15);
         if ($urandom_range(0, 3) == 0) fk[fk.size()-1] = 8'h00;
         send_frame(fd.size(), 1'b1, 3);
      end
      wait_idle();

      // Reset mid-frame discards the partial word.
      rdy_mode = 0;
      make_frame(4, 50);
      send_frame(2, 1'b0, 0);
      Rst = 1'b1;
      mdl_frames = '0;
      mdl_bad = '0;
      check_reset_outputs("rst1");
      @(posedge SysClk); #1;
      Rst = 1'b0;
      @(posedge SysClk); #1;
      make_frame(4, 0);
      foreach (fk[i]) fk[i] = 8'hFF;
      send_frame(4, 1'b1, 0);
      check("rst1_new_keep", m_axis_tkeep, 32'hFFFFFFFF);
      wait_idle();
      check("rst1_frames", stat_frames, 1);
      check("rst1_bad", stat_bad_frames, 0);

      // Counter wrap.
      #1 force dut.frames_q = '1;
      #1 release dut.frames_q;
      mdl_frames = '1;
      @(posedge SysClk); #1;
      check("wrap_preload", stat_frames, {CNT_W{1'b1}});
      make_frame(2, 0);
      send_frame(2, 1'b1, 0);
      wait_idle();
      check("wrap_zero", stat_frames, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
